// File: rtl/rom_seq_pkg.sv
// Shared types and helpers for the rom_seq ROM read sequencer.
package rom_seq_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } state_e;

  // $clog2 that never returns 0, so a degenerate counter/index still has a 1-bit register.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_seq_timer.sv
// Loadable down-counter pacing each ROM byte access; zero_o marks the sampling edge.
module rom_seq_timer
  import rom_seq_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  localparam int unsigned CntW = clog2_min1(WAIT_CYCLES);
  localparam logic [CntW-1:0] LoadVal = CntW'(WAIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rom_seq.sv
// Word-read sequencer for an async parallel ROM: WORD_BYTES byte reads assembled little-endian.
// Define ROM_SEQ_CACHE_EN to add a one-entry word cache that skips repeat fetches.
module rom_seq
  import rom_seq_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 13,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned WORD_BYTES  = 2,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic                                     clk_i,
  input  logic                                     nreset_i,
  input  logic                                     req_i,
  input  logic [ADDR_BITS-$clog2(WORD_BYTES)-1:0]  addr_i,
  output logic                                     rdy_o,
  output logic                                     valid_o,
  output logic [DATA_BITS*WORD_BYTES-1:0]          rdata_o,
  output logic [ADDR_BITS-1:0]                     rom_a_o,
  input  logic [DATA_BITS-1:0]                     rom_d_i,
  output logic                                     rom_nce_o,
  output logic                                     rom_noe_o
);

  localparam int unsigned LaneBits  = $clog2(WORD_BYTES);
  localparam int unsigned IdxW      = clog2_min1(WORD_BYTES);
  localparam int unsigned WordAddrW = ADDR_BITS - LaneBits;
  localparam int unsigned WordW     = DATA_BITS * WORD_BYTES;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_BYTES - 1);

  state_e                 state_q;
  logic [WordAddrW-1:0]   waddr_q;
  logic [IdxW-1:0]        idx_q;
  logic [IdxW-1:0]        idx_nxt;
  logic [WordW-1:0]       lanes_q;
  logic [WordW-1:0]       asm_word;
  logic [WordW-1:0]       rdata_q;
  logic [ADDR_BITS-1:0]   rom_a_q;
  logic                   nce_q, noe_q, rdy_q, valid_q;
  logic                   cnt_zero, last_lane, accept, hit, fetch_done, timer_load;

  function automatic logic [ADDR_BITS-1:0] byte_addr(input logic [WordAddrW-1:0] w,
                                                      input logic [IdxW-1:0]      i);
    return (ADDR_BITS'(w) << LaneBits) | ADDR_BITS'(i);
  endfunction

  always_comb begin
    asm_word = lanes_q;
    for (int unsigned k = 0; k < WORD_BYTES; k++) begin
      if (idx_q == IdxW'(k)) asm_word[k*DATA_BITS +: DATA_BITS] = rom_d_i;
    end
  end

  assign idx_nxt    = idx_q + 1'b1;
  assign last_lane  = (idx_q == LastIdx);
  assign accept     = (state_q == StIdle) && req_i;
  assign fetch_done = (state_q == StAccess) && cnt_zero && last_lane;
  assign timer_load = (accept && !hit) || ((state_q == StAccess) && cnt_zero && !last_lane);

`ifdef ROM_SEQ_CACHE_EN
  logic [WordAddrW-1:0] tag_q;
  logic                 tag_ok_q;

  assign hit = tag_ok_q && (addr_i == tag_q);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      tag_q    <= '0;
      tag_ok_q <= 1'b0;
    end else if (fetch_done) begin
      tag_q    <= waddr_q;
      tag_ok_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  rom_seq_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk_i (clk_i),
    .rst_ni(nreset_i),
    .load_i(timer_load),
    .en_i  (state_q == StAccess),
    .zero_o(cnt_zero)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= StIdle;
      waddr_q <= '0;
      idx_q   <= '0;
      lanes_q <= '0;
      rdata_q <= '0;
      rom_a_q <= '0;
      nce_q   <= 1'b1;
      noe_q   <= 1'b1;
      rdy_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (hit) begin
              // Cached word is already in rdata; just acknowledge.
              valid_q <= 1'b1;
            end else begin
              waddr_q <= addr_i;
              idx_q   <= '0;
              rom_a_q <= byte_addr(addr_i, '0);
              nce_q   <= 1'b0;
              noe_q   <= 1'b0;
              rdy_q   <= 1'b0;
              state_q <= StAccess;
            end
          end
        end
        StAccess: begin
          if (cnt_zero) begin
            lanes_q <= asm_word;
            if (last_lane) begin
              rdata_q <= asm_word;
              valid_q <= 1'b1;
              rdy_q   <= 1'b1;
              nce_q   <= 1'b1;
              noe_q   <= 1'b1;
              state_q <= StIdle;
            end else begin
              idx_q   <= idx_nxt;
              rom_a_q <= byte_addr(waddr_q, idx_nxt);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdy_o     = rdy_q;
  assign valid_o   = valid_q;
  assign rdata_o   = rdata_q;
  assign rom_a_o   = rom_a_q;
  assign rom_nce_o = nce_q;
  assign rom_noe_o = noe_q;

endmodule

// File: tb/tb_rom_seq.sv
// Directed bench for rom_seq: default build plus a 4-lane/2-wait instance on a slower clock.
module tb_rom_seq;

  logic        clk, clk_s, nreset;
  logic        req, rdy, valid, nce, noe;
  logic [11:0] addr;
  logic [15:0] rdata;
  logic [12:0] rom_a;
  logic [7:0]  rom_d;

  logic        req4, rdy4, valid4, nce4, noe4;
  logic [10:0] addr4;
  logic [31:0] rdata4;
  logic [12:0] rom_a4;
  logic [7:0]  rom_d4;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int pulses;

  // Async ROM models: byte[i] = i[7:0]^5A, 70 time-unit access.
  assign #70 rom_d  = (!nce && !noe) ? (rom_a[7:0] ^ 8'h5A) : 8'h00;
  assign #70 rom_d4 = (!nce4 && !noe4) ? (rom_a4[7:0] ^ 8'h5A) : 8'h00;

  rom_seq u_dut (
    .clk_i    (clk),
    .nreset_i (nreset),
    .req_i    (req),
    .addr_i   (addr),
    .rdy_o    (rdy),
    .valid_o  (valid),
    .rdata_o  (rdata),
    .rom_a_o  (rom_a),
    .rom_d_i  (rom_d),
    .rom_nce_o(nce),
    .rom_noe_o(noe)
  );

  rom_seq #(
    .WORD_BYTES (4),
    .WAIT_CYCLES(2)
  ) u_dut4 (
    .clk_i    (clk_s),
    .nreset_i (nreset),
    .req_i    (req4),
    .addr_i   (addr4),
    .rdy_o    (rdy4),
    .valid_o  (valid4),
    .rdata_o  (rdata4),
    .rom_a_o  (rom_a4),
    .rom_d_i  (rom_d4),
    .rom_nce_o(nce4),
    .rom_noe_o(noe4)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    clk_s = 1'b0;
    forever #20 clk_s = ~clk_s;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until valid is seen; a timeout returns max and trips the caller's check.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < max);
  endtask

  initial begin
    nreset = 1'b0;
    req    = 1'b0;
    addr   = '0;
    req4   = 1'b0;
    addr4  = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_valid", valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rom_a", rom_a, 0);
    check("rst_nce", nce, 1);
    check("rst_noe", noe, 1);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // Single read of word 3: bytes 6,7.
    req  = 1'b1;
    addr = 12'h003;
    for (int e = 0; e <= 9; e++) begin
      @(negedge clk);
      if (e == 0) begin
        req = 1'b0;
        check("sr_rdy", rdy, 0);
        check("sr_nce", nce, 0);
        check("sr_noe", noe, 0);
        check("sr_a0", rom_a, 13'h006);
      end
      if (e == 3) check("sr_a0_hold", rom_a, 13'h006);
      if (e == 4) check("sr_a1", rom_a, 13'h007);
      if (e == 7) check("sr_early", valid, 0);
      if (e == 8) begin
        check("sr_valid", valid, 1);
        check("sr_rdata", rdata, 16'h5D5C);
        check("sr_rdy_back", rdy, 1);
        check("sr_nce_off", nce, 1);
      end
      if (e == 9) begin
        check("sr_pulse", valid, 0);
        check("sr_hold", rdata, 16'h5D5C);
      end
    end

    // Back-to-back with req held high.
    req  = 1'b1;
    addr = 12'h000;
    @(negedge clk);
    addr = 12'h001;
    check("b2b_busy", rdy, 0);
    wait_valid(16, cyc);
    check("b2b_lat0", cyc, 8);
    check("b2b_data0", rdata, 16'h5B5A);
    check("b2b_ce_gap", nce, 1);
    @(negedge clk);
    req = 1'b0;
    check("b2b_restart", nce, 0);
    check("b2b_a", rom_a, 13'h002);
    wait_valid(16, cyc);
    check("b2b_lat1", cyc, 8);
    check("b2b_data1", rdata, 16'h5958);

    // Request during ACCESS is dropped.
    @(negedge clk);
    req  = 1'b1;
    addr = 12'h003;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req  = 1'b1;
    addr = 12'h005;
    @(negedge clk);
    req = 1'b0;
    wait_valid(16, cyc);
    check("busy_lat", cyc, 6);
    check("busy_data", rdata, 16'h5D5C);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid || !nce) pulses++;
    end
    check("busy_noqueue", pulses, 0);

    // Reset three cycles into ACCESS.
    req  = 1'b1;
    addr = 12'h000;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_pre_nce", nce, 0);
    nreset = 1'b0;
    #1;
    check("mid_nce", nce, 1);
    check("mid_noe", noe, 1);
    check("mid_rdy", rdy, 1);
    @(negedge clk);
    nreset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid) pulses++;
    end
    check("mid_novalid", pulses, 0);
    check("mid_rdata", rdata, 0);

    // Same word twice: cache hit when enabled, full refetch otherwise.
    req  = 1'b1;
    addr = 12'h003;
    @(negedge clk);
    req = 1'b0;
    wait_valid(16, cyc);
    check("rep_first", rdata, 16'h5D5C);
    @(negedge clk);
    req  = 1'b1;
    addr = 12'h003;
    @(negedge clk);
    req = 1'b0;
`ifdef ROM_SEQ_CACHE_EN
    check("hit_valid", valid, 1);
    check("hit_nce", nce, 1);
    check("hit_rdy", rdy, 1);
    check("hit_rdata", rdata, 16'h5D5C);
`else
    check("miss_nce", nce, 0);
    wait_valid(16, cyc);
    check("miss_lat", cyc, 8);
    check("miss_rdata", rdata, 16'h5D5C);
`endif

    // Top word of the 4-lane instance: bytes 1FFC..1FFF.
    @(negedge clk_s);
    req4  = 1'b1;
    addr4 = 11'h7FF;
    for (int e = 0; e <= 8; e++) begin
      @(negedge clk_s);
      if (e == 0) req4 = 1'b0;
      if ((e % 2) == 0 && e < 8) check("top_a", {19'd0, rom_a4}, 32'h1FFC + e / 2);
      if (e == 7) check("top_early", valid4, 0);
      if (e == 8) begin
        check("top_valid", valid4, 1);
        check("top_rdata", rdata4, 32'hA5A4A7A6);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
